// File: rtl/uart_rx_capture.sv
// rtl/uart_rx_capture.sv - oversampling UART receiver with glitch rejection, error flags and FWFT receive FIFO
//
// Purpose:
//   Resynchronises an asynchronous serial line, frames start/data/[parity]/stop
//   bits at a runtime-selectable bit period and buffers good bytes in a
//   first-word-fall-through FIFO.
//
// Optional feature macro:
//   UART_RX_PARITY_EN  defined   -> parity bit expected after the data bits,
//                                   parity_err_o is live
//                      undefined -> no parity bit, parity_err_o tied 0
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   rx_i          serial input, idle high, asynchronous to clk
//   div_i         bit period in clk cycles, 0 selects CLKS_PER_BIT
//   rd_valid_o    FIFO non-empty, rd_data_o valid
//   rd_data_o     head-of-FIFO byte (0 while empty)
//   rd_ready_i    pop when rd_valid_o & rd_ready_i
//   fifo_count_o  number of entries held
//   frame_err_o   1-cycle pulse: stop bit sampled low, byte discarded
//   parity_err_o  1-cycle pulse: parity mismatch, byte discarded
//   overrun_o     1-cycle pulse: good byte dropped because the FIFO was full

module uart_rx_capture #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 236,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int PARITY_ODD   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_i,
  input  logic [15:0]                     div_i,
  output logic                            rd_valid_o,
  output logic [DATA_BITS-1:0]            rd_data_o,
  input  logic                            rd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic                            frame_err_o,
  output logic                            parity_err_o,
  output logic                            overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DEF_PER   = 16'(CLKS_PER_BIT);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_STAGES < 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_rx_capture: illegal parameter combination");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Input synchroniser and start-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_q;
  logic                   start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rxs_q  <= rxs;
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];
  // Requiring the previous sample to be high means a line held low (break)
  // after a framing error cannot retrigger until it has returned to idle.
  assign start_edge = rxs_q & ~rxs;

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            period_q, period_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ferr_d;
  logic                   push;
  logic                   tick;
  logic [15:0]            p_sel;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   perr_d;
`endif

  assign tick  = (cnt_q == 16'd0);
  assign p_sel = (div_i != 16'd0) ? div_i : DEF_PER;

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? cnt_q : (cnt_q - 16'd1);
    period_d = period_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ferr_d   = 1'b0;
    push     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          // Half a period lands the start sample in the middle of the bit.
          period_d = p_sel;
          cnt_d    = {1'b0, p_sel[15:1]} - 16'd1;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (rxs) begin
            // Line already back high: treat as a glitch, silently.
            state_d = S_IDLE;
          end else begin
            cnt_d   = period_q - 16'd1;
            bit_d   = 4'd0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          cnt_d   = period_q - 16'd1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          // Even: line bit must equal XOR of data; odd: its complement.
          par_bad_d = rxs ^ (^shift_q) ^ PARITY_ODD[0];
          cnt_d     = period_q - 16'd1;
          state_d   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          if (!rxs) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            push = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      period_q <= DEF_PER;
      bit_q    <= 4'd0;
      shift_q  <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = ~empty & rd_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status pulses: all land on the cycle after the stop sample
  // ---------------------------------------------------------------------------
  logic frame_err_q;
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_d;
      overrun_q   <= push & full & ~pop;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= perr_d;
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rd_valid_o   = ~empty;
  assign rd_data_o    = empty ? '0 : mem[rd_ptr_q];
  assign fifo_count_o = count_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;

endmodule
